// File: rtl/sqrt_rr_scheduler_pkg.sv
// Shared types and default constants for the round-robin square-root scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int SQRT_LAT_DEF = 40;
    localparam int W_DEF        = 8;

endpackage

// File: rtl/sqrt_rr_scheduler_if.sv
// Request/response and calculator-side signals of the square-root scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_ready is the only flow control; requesters hold req_valid until it is seen.
interface sqrt_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) ();
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_x;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   resp_valid;
    logic [IW-1:0]      resp_id;
    logic [W-1:0]       resp_sqrt;
    logic               busy;
    logic               sq_start;
    logic [W-1:0]       sq_x;
    logic [W-1:0]       sq_result;

    // Scheduler side
    modport slave (
        input  req_valid, req_x, sq_result,
        output req_ready, resp_valid, resp_id, resp_sqrt, busy, sq_start, sq_x
    );

    // Client and calculator side
    modport master (
        output req_valid, req_x, sq_result,
        input  req_ready, resp_valid, resp_id, resp_sqrt, busy, sq_start, sq_x
    );
endinterface

// File: rtl/sqrt_rr_scheduler_arbiter.sv
// Round-robin request picker: first asserted req at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_id,
    output logic             any
);
    int idx;

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Shares one fixed-latency integer square-root unit among N_REQ requesters, round-robin.
// Latency: accept at t, start pulse t+1, response pulse t+2+SQRT_LAT, idle again t+3+SQRT_LAT.
// Backpressure: one operation in flight; other requesters wait (req_ready low) until IDLE.
module sqrt_rr_scheduler
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int W        = W_DEF,
    parameter int SQRT_LAT = SQRT_LAT_DEF
) (
    input  logic               CLK,
    input  logic               Reset,
    sqrt_rr_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    // Wide enough to hold SQRT_LAT-1 even when SQRT_LAT is 1.
    localparam int CW = $clog2(SQRT_LAT + 1);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    ptr_q;
    logic [W-1:0]     sq_x_q;
    logic [IW-1:0]    resp_id_q;
    logic [W-1:0]     resp_sqrt_q;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    logic             any_req;
    logic [N_REQ-1:0] resp_vld_oh;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any_req)
    );

    // Next-state logic: fixed walk IDLE->START->WAIT(counted)->DONE->IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch the granted operand/id, run the wait counter, capture the result, advance ptr.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q       <= '0;
            ptr_q       <= '0;
            sq_x_q      <= '0;
            resp_id_q   <= '0;
            resp_sqrt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sq_x_q    <= bus.req_x[int'(gnt_id)*W +: W];
                        resp_id_q <= gnt_id;
                    end
                end
                START: begin
                    cnt_q <= CW'(SQRT_LAT - 1);
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        resp_sqrt_q <= bus.sq_result;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    ptr_q <= (int'(resp_id_q) == N_REQ - 1) ? '0 : resp_id_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // One-hot response strobe towards the requester being answered.
    always_comb begin
        resp_vld_oh = '0;
        if (state_q == DONE && !Reset) begin
            resp_vld_oh[resp_id_q] = 1'b1;
        end
    end

    // Strobes are forced low while Reset is held so nothing leaks out before the state clears.
    assign bus.req_ready  = (state_q == IDLE && !Reset) ? gnt : '0;
    assign bus.sq_start   = (state_q == START) && !Reset;
    assign bus.busy       = (state_q != IDLE) && !Reset;
    assign bus.resp_valid = resp_vld_oh;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sqrt  = resp_sqrt_q;
    assign bus.sq_x       = sq_x_q;
endmodule

// File: doc/sqrt_rr_scheduler.md
# sqrt_rr_scheduler

Round-robin scheduler that shares one `Int_SQRT_Calculator` among `N_REQ` requesters. It accepts one request at a time and drives the calculator's start strobe `S` and operand `X` with a one-cycle start. It waits a fixed `SQRT_LAT` cycles, then captures `sqrt` and returns it to the granted requester with a one-cycle response pulse. It sits between the client logic and the single calculator instance; the calculator runs on the same `CLK` and `Reset`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 8: operand/result width.
- `SQRT_LAT`, default 40: cycles from start pulse to valid calculator result; minimum 1.
- `CLK`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_x`  in  N_REQ*W  operands, flattened; requester i uses bits [i*W +: W].
- `req_ready`  out  N_REQ  one-hot, high in the accept cycle only.
- `resp_valid`  out  N_REQ  one-hot, one-cycle result pulse.
- `resp_id`  out  $clog2(N_REQ)  index of the requester being answered; valid with `resp_valid`.
- `resp_sqrt`  out  W  result, floor(sqrt(x)); valid with `resp_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sq_start`  out  1  to calculator `S`.
- `sq_x`  out  W  to calculator `X`.
- `sq_result`  in  W  from calculator `sqrt`.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid`, grant g and go to START.
  - START: go to WAIT.
  - WAIT: go to DONE when the down-counter reaches 0.
  - DONE: go to IDLE.
- IDLE grant:
  - Select g = first asserted `req_valid` searching from `ptr` upward, wrapping modulo `N_REQ`.
  - Drive `req_ready[g]`=1 in that cycle (combinational from state and `req_valid`).
  - Latch `req_x[g]` into the `sq_x` register and g into the `resp_id` register.
- START: `sq_start`=1 for exactly this cycle; load counter with `SQRT_LAT-1`.
- WAIT: decrement the counter; `sq_x` is held stable.
  - At the edge that leaves WAIT, register `sq_result` into `resp_sqrt`.
- DONE:
  - `resp_valid[resp_id]`=1.
  - `ptr` ← (resp_id+1) mod `N_REQ`.
- Requests are non-preemptive: a `req_valid` that rises during service waits for IDLE.
- Dropping `req_valid` before it is accepted has no effect.
- Changes to `req_x` after acceptance are ignored.
- Reset values:
  - State IDLE, `ptr`=0, counter 0.
  - `sq_start`=0, `sq_x`=0, `resp_valid`=0, `resp_id`=0, `resp_sqrt`=0, `busy`=0, `req_ready`=0.
- Reset in any state:
  - The in-flight operation is abandoned with no `resp_valid`.
  - The next request after reset is arbitrated with `ptr`=0.

## Timing
- Accept in cycle t. `sq_start`=1 in t+1. WAIT spans t+2..t+1+`SQRT_LAT`. `resp_valid` is high in t+2+`SQRT_LAT`.
- Back in IDLE at t+3+`SQRT_LAT`; a new accept is possible in that cycle.
- Throughput: one operation per `SQRT_LAT`+3 cycles.
- `resp_sqrt` and `resp_id` hold their values until the next DONE.
- `sq_x` changes only on an accept edge.
- `req_ready` and `resp_valid` are never high in the same cycle.

## Structure
- Package `sqrt_sched_pkg` holds:
  - State enum `sched_state_t` {IDLE, START, WAIT, DONE}.
  - Default constants `SQRT_LAT_DEF`=40 and `W_DEF`=8.
- Sub-module `rr_arbiter`:
  - Parameterised by `N_REQ`.
  - Inputs: `req`, `ptr`. Outputs: one-hot `gnt`, index `gnt_id`, `any`.
  - Purely combinational; the top instantiates it once.

## Test plan
Bench: `N_REQ`=4, `SQRT_LAT`=40, with a behavioural calculator model of the same latency.

1. Hold `Reset`=1 for 3 cycles with random `req_valid` -> every output is 0 and `busy`=0 throughout.
2. Only `req_valid[2]`, x=245 -> `req_ready[2]` in cycle t, `sq_start` in t+1 with `sq_x`=245, `resp_valid[2]` in t+42 with `resp_sqrt`=15 and `resp_id`=2.
3. After reset, all four valid with x=1,4,100,255, each held until accepted -> grants in order 0,1,2,3, accepts 43 cycles apart, results 1,2,10,15.
4. After serving requester 1, `req_valid[0]` and `req_valid[2]` both high -> 2 is granted first, then 0.
5. `Reset` pulsed at WAIT cycle 20 -> no `resp_valid`; a following request on line 3 (x=0) returns `resp_sqrt`=0 with `ptr` behaviour starting from 0.
6. `req_x[1]` changes from 64 to 9 one cycle after acceptance -> `resp_sqrt`=8; `sq_x` stays 64 through WAIT.
